// File: rtl/debug_unit.sv
// Board-side debug front end: debounced step/inc/dec buttons, single-step or
// continuous run control, browse address counter and 7-seg/LED view muxing.

module debug_unit_db #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synced samples that disagree with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module debug_unit #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 succ,
  input  logic                 step,
  input  logic                 inc,
  input  logic                 dec,
  input  logic [2:0]           sel,
  input  logic                 m_rf,
  input  logic [7*WIDTH+11:0]  status,
  input  logic [WIDTH-1:0]     m_data,
  input  logic [WIDTH-1:0]     rf_data,
  output logic                 run,
  output logic [ADDR_W-1:0]    m_rf_addr,
  output logic [11:0]          led,
  output logic [WIDTH-1:0]     seg_data
);
  localparam int NUM_BTN = 3;  // bit 0 step, bit 1 inc, bit 2 dec

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  state_t              state;
  logic [1:0]          succ_sync;
  logic                succ_s;
  logic                succ_q;
  logic [NUM_BTN-1:0]  btn_raw;
  logic [NUM_BTN-1:0]  btn_level;
  logic [NUM_BTN-1:0]  btn_level_q;
  logic [NUM_BTN-1:0]  btn_pulse;
  logic                step_level;
  logic                step_pulse;
  logic                inc_pulse;
  logic                dec_pulse;
  logic [2:0]          word_idx;
  logic [11:0]         ctrl;

  assign btn_raw = {dec, inc, step};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debug_unit_db #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_raw[i]),
      .level (btn_level[i])
    );
  end

  assign btn_pulse  = btn_level & ~btn_level_q;
  assign step_level = btn_level[0];
  assign step_pulse = btn_pulse[0];
  assign inc_pulse  = btn_pulse[1];
  assign dec_pulse  = btn_pulse[2];
  assign succ_s     = succ_sync[1];

  // sel 1..7 selects pc_in..m_rd, which sit at word 6..0 of status
  assign word_idx = 3'd7 - sel;
  assign ctrl     = status[7*WIDTH +: 12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      succ_sync   <= '0;
      succ_q      <= 1'b0;
      btn_level_q <= '0;
    end else begin
      succ_sync   <= {succ_sync[0], succ};
      succ_q      <= succ_s;
      btn_level_q <= btn_level;
    end
  end

  // The cycle succ_s drops is treated like continuous mode for state tracking,
  // so a step press landing on it is swallowed (parked in HOLD until release).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run   <= 1'b0;
    end else if (succ_s) begin
      run   <= 1'b1;
      state <= step_level ? HOLD : IDLE;
    end else if (succ_q) begin
      run   <= 1'b0;
      state <= step_level ? HOLD : IDLE;
    end else begin
      case (state)
        IDLE: begin
          run <= step_pulse;
          if (step_pulse) state <= PULSE;
        end
        PULSE: begin
          run   <= 1'b0;
          state <= HOLD;
        end
        HOLD: begin
          run <= 1'b0;
          if (!step_level) state <= IDLE;
        end
        default: begin
          run   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rf_addr <= '0;
    end else if (sel == 3'd0 && (inc_pulse ^ dec_pulse)) begin
      m_rf_addr <= inc_pulse ? m_rf_addr + ADDR_W'(1) : m_rf_addr - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led      <= '0;
      seg_data <= '0;
    end else if (sel == 3'd0) begin
      led      <= 12'(m_rf_addr);
      seg_data <= m_rf ? m_data : rf_data;
    end else begin
      led      <= ctrl;
      seg_data <= status[WIDTH*word_idx +: WIDTH];
    end
  end
endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a history-based behavioural model.

module tb_debug_unit;
  localparam int DB = 4;
  localparam int HL = DB + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        succ = 0, step = 0, inc = 0, dec = 0;
  logic [2:0]  sel = 0;
  logic        m_rf = 0;
  logic [235:0] status;
  logic [31:0] m_data, rf_data;
  logic        run;
  logic [7:0]  m_rf_addr;
  logic [11:0] led;
  logic [31:0] seg_data;

  logic [31:0] st_w [7];
  logic [11:0] ctrl_w;
  logic [31:0] mem_m [256];
  logic [31:0] mem_r [256];

  int checks = 0;
  int failures = 0;
  bit check_en = 0;

  assign status  = {ctrl_w, st_w[6], st_w[5], st_w[4], st_w[3], st_w[2], st_w[1], st_w[0]};
  assign m_data  = mem_m[m_rf_addr];
  assign rf_data = mem_r[m_rf_addr];

  debug_unit #(.WIDTH(32), .ADDR_W(8), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .succ      (succ),
    .step      (step),
    .inc       (inc),
    .dec       (dec),
    .sel       (sel),
    .m_rf      (m_rf),
    .status    (status),
    .m_data    (m_data),
    .rf_data   (rf_data),
    .run       (run),
    .m_rf_addr (m_rf_addr),
    .led       (led),
    .seg_data  (seg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: hist[j] holds raw {succ,dec,inc,step} seen j edges ago.
  logic [3:0]  hist [HL];
  logic [2:0]  m_lvl, m_lvl_prev, m_pulse;
  logic        m_run, s_now, s_old, flip;
  logic [7:0]  m_addr, a_old;
  logic [11:0] m_led;
  logic [31:0] m_seg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HL; i++) hist[i] = 4'b0;
      m_lvl = 0; m_lvl_prev = 0; m_run = 0; m_addr = 0; m_led = 0; m_seg = 0;
    end else begin
      for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {succ, dec, inc, step};
      s_now   = hist[2][3];
      s_old   = hist[3][3];
      m_pulse = m_lvl & ~m_lvl_prev;
      a_old   = m_addr;
      m_run   = s_now || (!s_old && m_pulse[0]);
      if (sel == 0 && (m_pulse[1] ^ m_pulse[2]))
        m_addr = m_pulse[1] ? a_old + 8'd1 : a_old - 8'd1;
      m_led = (sel == 0) ? {4'b0, a_old} : ctrl_w;
      m_seg = (sel == 0) ? (m_rf ? mem_m[a_old] : mem_r[a_old]) : st_w[7 - sel];
      m_lvl_prev = m_lvl;
      for (int b = 0; b < 3; b++) begin
        flip = 1'b1;
        for (int j = 2; j < 2 + DB; j++) if (hist[j][b] == m_lvl_prev[b]) flip = 1'b0;
        if (flip) m_lvl[b] = ~m_lvl_prev[b];
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("run", {31'b0, run}, {31'b0, m_run});
      chk("addr", {24'b0, m_rf_addr}, {24'b0, m_addr});
      chk("led", {20'b0, led}, {20'b0, m_led});
      chk("seg", seg_data, m_seg);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic p_inc, input logic p_dec);
    inc = p_inc; dec = p_dec;
    cyc(10);
    inc = 0; dec = 0;
    cyc(10);
  endtask

  int first, cnt;
  bit found;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = $urandom;
      mem_r[i] = $urandom | 32'h1;
    end
    for (int i = 0; i < 7; i++) st_w[i] = $urandom;
    ctrl_w = 12'h3c1;

    #1 rst_n = 0;
    cyc(2);
    chk("reset_run", {31'b0, run}, 0);
    chk("reset_addr", {24'b0, m_rf_addr}, 0);
    chk("reset_led", {20'b0, led}, 0);
    chk("reset_seg", seg_data, 0);
    rst_n = 1;
    check_en = 1;
    cyc(2);

    // single step: one run pulse, DB+3 cycles after the press
    step = 1; first = -1; cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (run) begin cnt++; if (first < 0) first = k; end
    end
    step = 0;
    chk("step_latency", first, DB + 3);
    chk("step_pulses", cnt, 1);
    cyc(12);

    // bouncing button then steady high
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      step = (k < 10) ? ((k / 2) % 2 == 0) : 1'b1;
      @(negedge clk);
      if (run) cnt++;
    end
    step = 0;
    chk("bounce_pulses", cnt, 1);
    cyc(12);

    // continuous mode
    succ = 1;
    cyc(2); chk("cont_on_early", {31'b0, run}, 0);
    cyc(1); chk("cont_on", {31'b0, run}, 1);
    cyc(5); chk("cont_hold", {31'b0, run}, 1);
    succ = 0;
    cyc(2); chk("cont_off_early", {31'b0, run}, 1);
    cyc(1); chk("cont_off", {31'b0, run}, 0);
    cyc(5);

    // address wrap
    sel = 0; m_rf = 0;
    press(0, 1);
    chk("wrap_dec", {24'b0, m_rf_addr}, 32'd255);
    chk("wrap_led", {20'b0, led}, 32'd255);
    press(1, 0);
    chk("wrap_inc", {24'b0, m_rf_addr}, 0);
    press(0, 1);
    press(1, 1);
    chk("inc_dec_same", {24'b0, m_rf_addr}, 32'd255);

    // async reset in the middle of a run pulse
    step = 1; found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (run) found = 1;
    end
    chk("wait_run", {31'b0, found}, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_run", {31'b0, run}, 0);
    chk("rst_mid_addr", {24'b0, m_rf_addr}, 0);
    chk("rst_mid_led", {20'b0, led}, 0);
    chk("rst_mid_seg", seg_data, 0);
    step = 0;
    cyc(2);
    rst_n = 1;
    cyc(3);

    // view mux
    st_w[5] = 32'h0000_3004; ctrl_w = 12'ha5c;
    sel = 2;
    cyc(1); chk("view_pc", seg_data, 32'h0000_3004);
    sel = 0; m_rf = 1;
    cyc(1); chk("view_mem", seg_data, mem_m[0]);
    m_rf = 0;
    cyc(1); chk("view_rf", seg_data, mem_r[0]);
    sel = 1;
    cyc(1); chk("view_ctrl", {20'b0, led}, 32'ha5c);

    // randomized traffic, checked every cycle by the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(11) == 0) step = ~step;
      if ($urandom_range(9) == 0) inc = ~inc;
      if ($urandom_range(9) == 0) dec = ~dec;
      if ($urandom_range(199) == 0) succ = ~succ;
      if ($urandom_range(39) == 0) sel = ($urandom_range(2) == 0) ? 3'($urandom_range(7)) : 3'd0;
      if ($urandom_range(19) == 0) m_rf = ~m_rf;
      if ($urandom_range(29) == 0) begin
        st_w[$urandom_range(6)] = $urandom;
        ctrl_w = 12'($urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
